// File: rtl/time_set_writer.sv
// rtl/time_set_writer.sv - Mode/Inc front-panel editor that writes BCD HH:MM into the time register
// Optional auto-repeat of held Inc: define TIME_SET_AUTOREPEAT_EN.
module time_set_writer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_PERIOD  = 10
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Mode,
    input  logic        Inc,
    input  logic [12:0] Q_cur,
    output logic [12:0] D,
    output logic        Enable,
    output logic        Editing,
    output logic        Field
);

    typedef enum logic [1:0] {IDLE, EDIT_HR, EDIT_MIN, COMMIT} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [12:0]   work_q, work_d;
    logic [12:0]   qcopy_q, qcopy_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mode_prev_q, mode_prev_d;
    logic          inc_prev_q, inc_prev_d;

    logic mode_edge, inc_edge, inc_evt, rpt_fire, in_edit;

    // Out-of-range fields (hand-loaded or corrupt) snap to 00 on the first increment.
    function automatic logic [12:0] next_hours(input logic [12:0] v);
        logic [1:0] ht;
        logic [3:0] ho;
        ht = v[12:11];
        ho = v[10:7];
        if (ht > 2'd2 || ho > 4'd9 || (ht == 2'd2 && ho > 4'd2))
            return {2'd0, 4'd0, v[6:0]};
        else if (ho == 4'd9)
            return {ht + 2'd1, 4'd0, v[6:0]};
        else
            return {ht, ho + 4'd1, v[6:0]};
    endfunction

    function automatic logic [12:0] next_minutes(input logic [12:0] v);
        logic [2:0] mt;
        logic [3:0] mo;
        mt = v[6:4];
        mo = v[3:0];
        if (mt > 3'd5 || mo > 4'd9 || (mt == 3'd5 && mo == 4'd9))
            return {v[12:7], 3'd0, 4'd0};
        else if (mo == 4'd9)
            return {v[12:7], mt + 3'd1, 4'd0};
        else
            return {v[12:7], mt, mo + 4'd1};
    endfunction

    assign mode_edge = Mode & ~mode_prev_q;
    assign inc_edge  = Inc & ~inc_prev_q;
    assign in_edit   = (state_q == EDIT_HR) || (state_q == EDIT_MIN);
    assign inc_evt   = inc_edge | rpt_fire;

`ifdef TIME_SET_AUTOREPEAT_EN
    logic        rpt_active_q, rpt_active_d;
    logic        rpt_phase_q, rpt_phase_d;
    logic [15:0] rpt_cnt_q, rpt_cnt_d;

    // Phase 0 waits out the initial delay, phase 1 paces the steady repeats.
    always_comb begin
        rpt_fire     = 1'b0;
        rpt_active_d = rpt_active_q;
        rpt_phase_d  = rpt_phase_q;
        rpt_cnt_d    = rpt_cnt_q;
        if (!in_edit || mode_edge || !Inc) begin
            rpt_active_d = 1'b0;
            rpt_phase_d  = 1'b0;
            rpt_cnt_d    = '0;
        end else if (inc_edge) begin
            rpt_active_d = 1'b1;
            rpt_phase_d  = 1'b0;
            rpt_cnt_d    = '0;
        end else if (rpt_active_q) begin
            if ((!rpt_phase_q && rpt_cnt_q == 16'(REPEAT_DELAY)) ||
                (rpt_phase_q && rpt_cnt_q == 16'(REPEAT_PERIOD - 1))) begin
                rpt_fire    = 1'b1;
                rpt_phase_d = 1'b1;
                rpt_cnt_d   = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            rpt_active_q <= 1'b0;
            rpt_phase_q  <= 1'b0;
            rpt_cnt_q    <= '0;
        end else begin
            rpt_active_q <= rpt_active_d;
            rpt_phase_q  <= rpt_phase_d;
            rpt_cnt_q    <= rpt_cnt_d;
        end
    end
`else
    logic [31:0] unused_rpt;
    assign unused_rpt = 32'(REPEAT_DELAY + REPEAT_PERIOD);
    assign rpt_fire   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        tmo_d       = tmo_q;
        qcopy_d     = Q_cur;
        mode_prev_d = Mode;
        inc_prev_d  = Inc;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (mode_edge) begin
                    work_d  = Q_cur;
                    state_d = EDIT_HR;
                end
            end
            EDIT_HR, EDIT_MIN: begin
                // Mode takes priority over a same-cycle Inc.
                if (mode_edge) begin
                    state_d = (state_q == EDIT_HR) ? EDIT_MIN : COMMIT;
                    tmo_d   = '0;
                end else if (inc_evt) begin
                    work_d = (state_q == EDIT_HR) ? next_hours(work_q) : next_minutes(work_q);
                    tmo_d  = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q     <= IDLE;
            work_q      <= '0;
            qcopy_q     <= '0;
            tmo_q       <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            qcopy_q     <= qcopy_d;
            tmo_q       <= tmo_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
        end
    end

    assign D       = (state_q == IDLE) ? qcopy_q : work_q;
    assign Enable  = (state_q == COMMIT);
    assign Editing = in_edit;
    assign Field   = (state_q == EDIT_MIN);

endmodule

// File: tb/tb_time_set_writer.sv
// tb/tb_time_set_writer.sv - directed self-checking bench for time_set_writer
module tb_time_set_writer;

    logic        Clock;
    logic        Clear;
    logic        Mode;
    logic        Inc;
    logic [12:0] Q_cur;
    logic [12:0] D;
    logic        Enable;
    logic        Editing;
    logic        Field;

    int n_checks = 0;
    int n_fail   = 0;
    int en_seen;

    time_set_writer dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .Mode   (Mode),
        .Inc    (Inc),
        .Q_cur  (Q_cur),
        .D      (D),
        .Enable (Enable),
        .Editing(Editing),
        .Field  (Field)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [12:0] enc(input int h, input int m);
        logic [1:0] ht;
        logic [3:0] ho;
        logic [2:0] mt;
        logic [3:0] mo;
        ht = 2'(h / 10);
        ho = 4'(h % 10);
        mt = 3'(m / 10);
        mo = 4'(m % 10);
        return {ht, ho, mt, mo};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic mode_pulse();
        Mode = 1'b1;
        tick();
        Mode = 1'b0;
        tick();
    endtask

    task automatic inc_pulse();
        Inc = 1'b1;
        tick();
        Inc = 1'b0;
        tick();
    endtask

    initial begin
        Clear = 1'b1;
        Mode  = 1'b0;
        Inc   = 1'b0;
        Q_cur = '0;
        #3;
        check("reset_D", D, 13'd0);
        check("reset_Enable", 13'(Enable), 13'd0);
        check("reset_Editing", 13'(Editing), 13'd0);
        check("reset_Field", 13'(Field), 13'd0);
        tick();
        Clear = 1'b0;

        // 09:58 -> 10:00
        Q_cur = enc(9, 58);
        tick();
        check("idle_track", D, enc(9, 58));
        mode_pulse();
        check("hr_editing", 13'(Editing), 13'd1);
        check("hr_field", 13'(Field), 13'd0);
        check("hr_capture", D, enc(9, 58));
        inc_pulse();
        check("hr_inc_9_10", D, enc(10, 58));
        mode_pulse();
        check("min_field", 13'(Field), 13'd1);
        inc_pulse();
        inc_pulse();
        check("min_wrap", D, enc(10, 0));
        Mode = 1'b1;
        tick();
        check("commit1_enable", 13'(Enable), 13'd1);
        check("commit1_D", D, 13'b01_0000_000_0000);
        Mode = 1'b0;
        tick();
        check("commit1_enable_off", 13'(Enable), 13'd0);
        check("commit1_idle", 13'(Editing), 13'd0);

        // 23:59 -> 00:00 with no carry from minutes into hours
        Q_cur = enc(23, 59);
        tick();
        mode_pulse();
        inc_pulse();
        check("hr_wrap_23", D, enc(0, 59));
        mode_pulse();
        inc_pulse();
        check("min_wrap_59", D, enc(0, 0));
        Mode = 1'b1;
        tick();
        check("commit2_enable", 13'(Enable), 13'd1);
        check("commit2_D", D, enc(0, 0));
        Mode = 1'b0;
        tick();

        // simultaneous Mode and Inc: Mode wins
        Q_cur = enc(12, 34);
        tick();
        mode_pulse();
        Mode = 1'b1;
        Inc  = 1'b1;
        tick();
        Mode = 1'b0;
        Inc  = 1'b0;
        tick();
        check("simul_field", 13'(Field), 13'd1);
        check("simul_D", D, enc(12, 34));
        inc_pulse();
        check("simul_min_inc", D, enc(12, 35));

        // asynchronous Clear mid EDIT_MIN
        #2;
        Clear = 1'b1;
        #1;
        check("clr_D", D, 13'd0);
        check("clr_Editing", 13'(Editing), 13'd0);
        check("clr_Field", 13'(Field), 13'd0);
        check("clr_Enable", 13'(Enable), 13'd0);
        Clear = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Enable) en_seen++;
        end
        check("clr_no_enable", 13'(en_seen), 13'd0);
        check("clr_track", D, enc(12, 34));

        // out-of-range capture: bad hours forced to 00, bad minutes written as-is
        Q_cur = {2'd2, 4'd5, 3'd5, 4'd12};
        tick();
        mode_pulse();
        inc_pulse();
        check("oor_hr_force", D, {2'd0, 4'd0, 3'd5, 4'd12});
        inc_pulse();
        check("oor_hr_inc", D, {2'd0, 4'd1, 3'd5, 4'd12});
        mode_pulse();
        Mode = 1'b1;
        tick();
        check("oor_commit_enable", 13'(Enable), 13'd1);
        check("oor_commit_D", D, {2'd0, 4'd1, 3'd5, 4'd12});
        Mode = 1'b0;
        tick();

        // timeout in EDIT_HR
        Q_cur = enc(5, 30);
        tick();
        mode_pulse();
        repeat (900) tick();
        check("tmo_still_edit", 13'(Editing), 13'd1);
        en_seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (Enable) en_seen++;
        end
        check("tmo_exit", 13'(Editing), 13'd0);
        check("tmo_no_enable", 13'(en_seen), 13'd0);
        Q_cur = enc(7, 7);
        tick();
        check("tmo_track", D, enc(7, 7));

        // Inc held in EDIT_MIN for 1 + 50 + 3*10 cycles
        Q_cur = enc(12, 0);
        tick();
        mode_pulse();
        mode_pulse();
        check("hold_field", 13'(Field), 13'd1);
        Inc = 1'b1;
        repeat (81) tick();
        Inc = 1'b0;
        tick();
`ifdef TIME_SET_AUTOREPEAT_EN
        check("hold_minutes", D, enc(12, 4));
`else
        check("hold_minutes", D, enc(12, 1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
